// File: rtl/adc_cap_pkg.sv
// Shared types and constants for the ADC triggered capture buffer.
package adc_cap_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE       = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        DONE      = 3'd4
    } cap_state_t;

    // trig_mode encodings; 2'b11 behaves as normal
    localparam logic [1:0] MODE_AUTO       = 2'b00;
    localparam logic [1:0] MODE_NORMAL     = 2'b01;
    localparam logic [1:0] MODE_SINGLE     = 2'b10;
    localparam logic [1:0] MODE_NORMAL_ALT = 2'b11;

endpackage

// File: rtl/adc_cap_dpram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module adc_cap_dpram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write port; contents are never cleared
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Registered read; output register holds its value when not enabled
    always_ff @(posedge clk) begin
        if (!rst_n)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/adc_capture_buf.sv
// Triggered capture buffer: decimation, pre-trigger history, level/edge
// trigger, post-trigger fill, and a rotated read port for the LCD renderer.
module adc_capture_buf
    import adc_cap_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 10,
    parameter int DEC_W   = 16,
    parameter int AUTO_TO = 4096
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_edge,
    input  logic [1:0]        trig_mode,
    input  logic [ADDR_W-1:0] pre_depth,
    input  logic [DEC_W-1:0]  dec_ratio,
    input  logic              arm,
    input  logic              rd_release,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [2:0]        cap_state,
    output logic              frame_done,
    output logic              forced
);

    localparam int TO_W = $clog2(AUTO_TO + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    cap_state_t        state;
    logic [ADDR_W-1:0] pre_l;
    logic [DEC_W-1:0]  dec_l;
    logic [1:0]        mode_l;
    logic              edge_l;
    logic [DATA_W-1:0] level_l;

    logic [DEC_W-1:0]  dec_cnt;
    logic [ADDR_W-1:0] smp_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] trig_ptr;
    logic [DATA_W-1:0] prev_smp;
    logic              prev_valid;

    logic              capturing;
    logic              kept;
    logic              hit;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;
    logic [ADDR_W-1:0] post_len;

    // Sample qualification, trigger comparison and read address rotation
    always_comb begin
        capturing = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
        kept      = capturing && smp_valid && (dec_cnt == dec_l);
        if (edge_l)
            hit = prev_valid && (prev_smp > level_l) && (smp_data <= level_l);
        else
            hit = prev_valid && (prev_smp < level_l) && (smp_data >= level_l);
        post_len  = LAST_IDX - pre_l;
        ram_re    = rd_en && (state == DONE);
        ram_raddr = trig_ptr - pre_l + rd_addr;
    end

    // Capture FSM with datapath counters and registered status outputs
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            pre_l      <= '0;
            dec_l      <= '0;
            mode_l     <= '0;
            edge_l     <= 1'b0;
            level_l    <= '0;
            dec_cnt    <= '0;
            smp_cnt    <= '0;
            to_cnt     <= '0;
            wr_ptr     <= '0;
            trig_ptr   <= '0;
            prev_smp   <= '0;
            prev_valid <= 1'b0;
            frame_done <= 1'b0;
            forced     <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            rd_valid   <= ram_re;

            if (capturing && smp_valid)
                dec_cnt <= (dec_cnt == dec_l) ? '0 : dec_cnt + 1'b1;

            if (kept) begin
                wr_ptr     <= wr_ptr + 1'b1;
                prev_smp   <= smp_data;
                prev_valid <= 1'b1;
            end

            if (arm) begin
                // ADDR_W-bit pre_depth can never exceed DEPTH-1, so the clamp is implicit
                pre_l      <= pre_depth;
                dec_l      <= dec_ratio;
                mode_l     <= trig_mode;
                edge_l     <= trig_edge;
                level_l    <= trig_level;
                dec_cnt    <= '0;
                smp_cnt    <= '0;
                to_cnt     <= '0;
                prev_valid <= 1'b0;
                forced     <= 1'b0;
                state      <= PRE;
            end else begin
                case (state)
                    IDLE: ;
                    PRE: begin
                        if (pre_l == '0) begin
                            state <= WAIT_TRIG;
                        end else if (kept) begin
                            if (smp_cnt == pre_l - 1'b1) begin
                                smp_cnt <= '0;
                                state   <= WAIT_TRIG;
                            end else begin
                                smp_cnt <= smp_cnt + 1'b1;
                            end
                        end
                    end
                    WAIT_TRIG: begin
                        if (kept) begin
                            if (hit) begin
                                trig_ptr <= wr_ptr;
                                state    <= POST;
                            end else if (mode_l == MODE_AUTO &&
                                         to_cnt == TO_W'(AUTO_TO - 1)) begin
                                trig_ptr <= wr_ptr;
                                forced   <= 1'b1;
                                state    <= POST;
                            end else begin
                                to_cnt <= to_cnt + 1'b1;
                            end
                        end
                    end
                    POST: begin
                        if (post_len == '0) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else if (kept) begin
                            if (smp_cnt == post_len - 1'b1) begin
                                smp_cnt    <= '0;
                                state      <= DONE;
                                frame_done <= 1'b1;
                            end else begin
                                smp_cnt <= smp_cnt + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (rd_release && mode_l != MODE_SINGLE) begin
                            dec_cnt    <= '0;
                            smp_cnt    <= '0;
                            to_cnt     <= '0;
                            prev_valid <= 1'b0;
                            forced     <= 1'b0;
                            state      <= PRE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign cap_state = state;

    adc_cap_dpram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .we    (kept),
        .waddr (wr_ptr),
        .wdata (smp_data),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (rd_data)
    );

endmodule

// File: doc/adc_capture_buf.md
Name: adc_capture_buf

Overview:
- Parametrised triggered capture buffer for the parallel ADC sample stream, replacing the fixed 8-bit sampling path that feeds the LCD waveform/character display.
- Decimates incoming samples, keeps a programmable pre-trigger history in a circular RAM, detects a level/edge trigger, then fills the post-trigger region.
- Presents the frame to the LCD renderer through a random-access read port, with addresses already rotated so that index 0 is the oldest sample.

Parameters:
- DATA_W, 8: sample width in bits.
- ADDR_W, 10: buffer address width; DEPTH = 2**ADDR_W.
- DEC_W, 16: decimation counter width.
- AUTO_TO, 4096: auto-mode timeout, in decimated samples.

Ports:
- sys_clk  in  1  system clock, the only clock.
- sys_rst_n  in  1  synchronous active-low reset.
- smp_valid  in  1  sample strobe; ADC data is already in the sys_clk domain.
- smp_data  in  DATA_W  ADC sample, unsigned.
- trig_level  in  DATA_W  trigger threshold.
- trig_edge  in  1  0 = rising, 1 = falling.
- trig_mode  in  2  00 auto, 01 normal, 10 single, 11 treated as normal.
- pre_depth  in  ADDR_W  number of pre-trigger samples.
- dec_ratio  in  DEC_W  keep 1 sample in every (dec_ratio+1).
- arm  in  1  pulse; starts or restarts a capture.
- rd_release  in  1  pulse; the LCD has finished reading the frame.
- rd_addr  in  ADDR_W  logical read index (0 = oldest sample).
- rd_en  in  1  read request.
- rd_data  out  DATA_W  sample read from the buffer.
- rd_valid  out  1  rd_data is valid.
- cap_state  out  3  current FSM state encoding.
- frame_done  out  1  one-cycle pulse on entry to DONE.
- forced  out  1  the last frame was taken by auto timeout.

Behaviour:
- Reset: synchronous and active-low; reset values are taken on the first sys_clk edge with sys_rst_n = 0.
  - State goes to IDLE.
  - All outputs are 0; internal pointers and counters are 0.
  - RAM contents are not cleared.
- Reset asserted mid-capture aborts the capture and returns to IDLE. It has priority over every other input.
- On arm:
  - pre_depth, dec_ratio, trig_mode, trig_edge and trig_level are latched.
  - pre_depth is clamped to DEPTH-1.
  - The decimation counter and sample counter are cleared, prev_valid is cleared and forced is cleared.
- Decimation:
  - The counter advances on each smp_valid.
  - A "kept" sample occurs when the counter equals the latched ratio; the counter then returns to 0.
  - dec_ratio = 0 keeps every sample.
  - Only kept samples are written or compared.
- Writes:
  - The write pointer wr_ptr increments modulo DEPTH on each kept sample during PRE, WAIT_TRIG and POST.
  - Wrap from DEPTH-1 to 0 is silent.
- Trigger detection on kept samples requires prev_valid:
  - Rising: prev < level and cur >= level.
  - Falling: prev > level and cur <= level.
- FSM:
  - IDLE -> PRE on arm.
  - PRE: count kept samples; move to WAIT_TRIG once pre_depth samples are stored. pre_depth = 0 moves to WAIT_TRIG on the next cycle. Triggers that occur during PRE are ignored.
  - WAIT_TRIG -> POST on a trigger.
    - trig_ptr takes the write address of the triggering sample.
    - The triggering sample is logical index pre_depth.
    - In auto mode, AUTO_TO kept samples without a trigger force the transition: trig_ptr = the current sample's address and forced = 1.
  - POST -> DONE when DEPTH - pre_depth - 1 further samples are stored. frame_done pulses for 1 cycle.
  - DONE:
    - Writes stop.
    - Auto/normal: rd_release -> PRE, a re-arm using the latched settings.
    - Single: stays in DONE until arm.
  - arm in any state restarts at PRE. arm and rd_release in the same cycle: arm wins.
- Reads:
  - Physical address = (trig_ptr - pre_depth + rd_addr) mod DEPTH.
  - Synchronous RAM with 1-cycle latency: rd_valid = rd_en delayed by 1 cycle, gated with state == DONE at request time.
  - Outside DONE, rd_valid = 0 and rd_data holds its last value.
- Arithmetic: all pointer arithmetic is unsigned, ADDR_W bits, wrapping.

Decomposition:
- Package adc_cap_pkg holds:
  - State enum: IDLE=0, PRE=1, WAIT_TRIG=2, POST=3, DONE=4.
  - trig_mode constants.
- Sub-module adc_cap_dpram: simple dual-port RAM, DATA_W x DEPTH, one write port and one registered read port, inferred as block RAM.

Test Plan:
- Reset mid-POST (sys_rst_n = 0 for 1 cycle) -> cap_state = 0, frame_done = 0, rd_valid = 0 on the following cycle.
- Ramp 0..255 repeating, smp_valid every cycle, level = 100, rising, normal mode, pre_depth = 256, dec_ratio = 0 -> frame_done pulses once; rd_addr = 256 returns 100; rd_addr = 255 returns 99; rd_valid is high 1 cycle after rd_en.
- Same ramp, falling edge, level = 10 -> the only trigger is the wrap 255->0 crossing; rd_addr = pre_depth returns 0.
- Constant input 50, auto mode, AUTO_TO = 4096 -> DONE reached with forced = 1; normal mode with the same input -> remains in WAIT_TRIG for more than 10000 cycles.
- dec_ratio = 3 on ramp -> consecutive logical reads differ by 4, modulo 256.
- Single mode: rd_release in DONE -> stays in DONE. arm plus rd_release in the same cycle in auto mode -> PRE with freshly latched settings. pre_depth = 1023 -> stored 1023 pre-trigger samples, trigger sample at index 1023.
